// File: rtl/clos_rr_sched.sv
// Round-robin pointer bank for a 3-stage Clos fabric: one pointer + stall counter per middle and egress arbiter.
// Define CLOS_RR_SCHED_LFSR_EN to randomise the advance step with a shared 16-bit Galois LFSR.
module clos_rr_sched #(
    parameter int ClosN       = 4,
    parameter int ClosM       = 8,
    parameter int ClosR       = 4,
    parameter int StallThresh = 15
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic                                              en_i,
    input  logic                                              clr_i,
    input  logic [ClosM-1:0][ClosR-1:0]                       mid_req_i,
    input  logic [ClosM-1:0][ClosR-1:0]                       mid_gnt_i,
    input  logic [ClosR-1:0][ClosN-1:0]                       egr_req_i,
    input  logic [ClosR-1:0][ClosN-1:0]                       egr_gnt_i,
    output logic [ClosM-1:0][ClosR-1:0][$clog2(ClosR)-1:0]    rr_mid_o,
    output logic [ClosR-1:0][ClosN-1:0][$clog2(ClosM)-1:0]    rr_egr_o,
    output logic                                              stall_o
);
    localparam int MidW = $clog2(ClosR);
    localparam int EgrW = $clog2(ClosM);
    localparam int CntW = $clog2(StallThresh + 1);
    localparam logic [CntW-1:0] ThrLast = CntW'(StallThresh - 1);

    if (ClosN < 2 || (ClosN & (ClosN - 1)) != 0) begin : g_bad_n
        $error("ClosN must be a power of two >= 2");
    end
    if (ClosM < 2 || (ClosM & (ClosM - 1)) != 0) begin : g_bad_m
        $error("ClosM must be a power of two >= 2");
    end
    if (ClosR < 2 || (ClosR & (ClosR - 1)) != 0) begin : g_bad_r
        $error("ClosR must be a power of two >= 2");
    end
    if (StallThresh < 1) begin : g_bad_thresh
        $error("StallThresh must be >= 1");
    end

    logic [MidW-1:0]          mid_step;
    logic [EgrW-1:0]          egr_step;
    logic [ClosM*ClosR-1:0]   mid_hit;
    logic [ClosR*ClosN-1:0]   egr_hit;

`ifdef CLOS_RR_SCHED_LFSR_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Galois form of x^16+x^14+x^13+x^11+1: shift right, fold bit 0 into the tap mask.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            lfsr_q <= 16'hACE1;
        end else if (en_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign mid_step = MidW'(1) + lfsr_q[MidW-1:0];
    assign egr_step = EgrW'(1) + lfsr_q[EgrW-1:0];
`else
    assign mid_step = MidW'(1);
    assign egr_step = EgrW'(1);
`endif

    for (genvar gi = 0; gi < ClosM; gi++) begin : g_mid_row
        for (genvar gj = 0; gj < ClosR; gj++) begin : g_mid
            localparam logic [MidW-1:0] Seed = MidW'((gi + gj) % ClosR);
            logic [MidW-1:0] ptr_q, ptr_d;
            logic [CntW-1:0] cnt_q, cnt_d;
            logic            req, hs, hit;

            always_comb begin
                req   = mid_req_i[gi][gj];
                hs    = req & mid_gnt_i[gi][gj];
                hit   = en_i & req & ~mid_gnt_i[gi][gj] & (cnt_q == ThrLast);
                ptr_d = ptr_q;
                cnt_d = cnt_q;
                if (en_i) begin
                    if (hs || hit) begin
                        ptr_d = ptr_q + mid_step;
                    end
                    if (hs || hit || !req) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i || clr_i) begin
                    ptr_q <= Seed;
                    cnt_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                    cnt_q <= cnt_d;
                end
            end

            assign rr_mid_o[gi][gj]        = ptr_q;
            assign mid_hit[gi*ClosR + gj]  = hit;
        end
    end

    for (genvar gi = 0; gi < ClosR; gi++) begin : g_egr_row
        for (genvar gj = 0; gj < ClosN; gj++) begin : g_egr
            localparam logic [EgrW-1:0] Seed = EgrW'((gi * ClosN + gj) % ClosM);
            logic [EgrW-1:0] ptr_q, ptr_d;
            logic [CntW-1:0] cnt_q, cnt_d;
            logic            req, hs, hit;

            always_comb begin
                req   = egr_req_i[gi][gj];
                hs    = req & egr_gnt_i[gi][gj];
                hit   = en_i & req & ~egr_gnt_i[gi][gj] & (cnt_q == ThrLast);
                ptr_d = ptr_q;
                cnt_d = cnt_q;
                if (en_i) begin
                    if (hs || hit) begin
                        ptr_d = ptr_q + egr_step;
                    end
                    if (hs || hit || !req) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i || clr_i) begin
                    ptr_q <= Seed;
                    cnt_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                    cnt_q <= cnt_d;
                end
            end

            assign rr_egr_o[gi][gj]        = ptr_q;
            assign egr_hit[gi*ClosN + gj]  = hit;
        end
    end

    // Zero-latency indication: reflects this cycle's forced advances.
    assign stall_o = |mid_hit | |egr_hit;

endmodule

// File: tb/tb_clos_rr_sched.sv
// Self-checking bench for clos_rr_sched: directed scenarios plus randomized traffic against a reference model.
module tb_clos_rr_sched;
    localparam int N  = 4;
    localparam int M  = 8;
    localparam int R  = 4;
    localparam int TH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, clr;
    logic [M-1:0][R-1:0]       mid_req, mid_gnt;
    logic [R-1:0][N-1:0]       egr_req, egr_gnt;
    logic [M-1:0][R-1:0][1:0]  rr_mid;
    logic [R-1:0][N-1:0][2:0]  rr_egr;
    logic                      stall_o;

    clos_rr_sched #(.ClosN(N), .ClosM(M), .ClosR(R), .StallThresh(TH)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
        .mid_req_i(mid_req), .mid_gnt_i(mid_gnt),
        .egr_req_i(egr_req), .egr_gnt_i(egr_gnt),
        .rr_mid_o(rr_mid), .rr_egr_o(rr_egr), .stall_o(stall_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: pointer and consecutive-blocked count per arbiter, plus LFSR value.
    int mp[M][R];
    int mc[M][R];
    int ep[R][N];
    int ec[R][N];
    int lf = 'hACE1;
    logic obs_stall;
    logic exp_stall;

    function automatic int adv_step(int size);
`ifdef CLOS_RR_SCHED_LFSR_EN
        return 1 + (lf % size);
`else
        return 1;
`endif
    endfunction

    task automatic arb(inout int p, inout int c, input bit rq, input bit gn,
                       input int size, input int seed);
        bit adv;
        if (rst || clr) begin
            p = seed;
            c = 0;
        end else if (en) begin
            adv = (rq && gn) || (rq && !gn && (c + 1 == TH));
            if (adv) p = (p + adv_step(size)) % size;
            c = (rq && !gn && !adv) ? c + 1 : 0;
        end
    endtask

    // One clock: sample stall_o mid-cycle, advance the model, land 1 time unit after the edge.
    task automatic tick();
        @(negedge clk);
        obs_stall = stall_o;
        exp_stall = 1'b0;
        if (en) begin
            for (int m = 0; m < M; m++)
                for (int r = 0; r < R; r++)
                    if (mid_req[m][r] && !mid_gnt[m][r] && mc[m][r] + 1 == TH) exp_stall = 1'b1;
            for (int r = 0; r < R; r++)
                for (int n = 0; n < N; n++)
                    if (egr_req[r][n] && !egr_gnt[r][n] && ec[r][n] + 1 == TH) exp_stall = 1'b1;
        end
        for (int m = 0; m < M; m++)
            for (int r = 0; r < R; r++)
                arb(mp[m][r], mc[m][r], mid_req[m][r], mid_gnt[m][r], R, (m + r) % R);
        for (int r = 0; r < R; r++)
            for (int n = 0; n < N; n++)
                arb(ep[r][n], ec[r][n], egr_req[r][n], egr_gnt[r][n], M, (r * N + n) % M);
        if (rst || clr) lf = 'hACE1;
        else if (en) lf = (lf >> 1) ^ ((lf & 1) != 0 ? 'hB400 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_reset();
        mid_req = '0; mid_gnt = '0; egr_req = '0; egr_gnt = '0;
        en = 1'b0; clr = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        quiet_reset();
        tick();
        n_cmp++;
        if (rr_mid[2][3] !== 2'd1) begin
            n_bad++; $display("FAIL reset_mid23 got %0d want 1", rr_mid[2][3]);
        end
        n_cmp++;
        if (rr_egr[1][2] !== 3'd6) begin
            n_bad++; $display("FAIL reset_egr12 got %0d want 6", rr_egr[1][2]);
        end
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_stall got %b want 0", stall_o);
        end
        bad = 0;
        for (int m = 0; m < M; m++)
            for (int r = 0; r < R; r++)
                if (int'(rr_mid[m][r]) != (m + r) % R) bad++;
        for (int r = 0; r < R; r++)
            for (int n = 0; n < N; n++)
                if (int'(rr_egr[r][n]) != (r * N + n) % M) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL reset_seeds got %0d wrong pointers want 0", bad);
        end
    endtask

    task automatic test_handshake();
        int seq[5] = '{1, 2, 3, 0, 1};
        quiet_reset();
        n_cmp++;
        if (rr_mid[0][0] !== 2'd0) begin
            n_bad++; $display("FAIL hs_start got %0d want 0", rr_mid[0][0]);
        end
        en = 1'b1; mid_req[0][0] = 1'b1; mid_gnt[0][0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (int'(rr_mid[0][0]) != seq[k]) begin
                n_bad++; $display("FAIL hs_seq[%0d] got %0d want %0d", k, rr_mid[0][0], seq[k]);
            end
        end
        mid_req = '0; mid_gnt = '0;
    endtask

    task automatic test_stall();
        logic exp_s[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int   exp_p[6] = '{0, 0, 1, 1, 1, 2};
        quiet_reset();
        en = 1'b1; egr_req[0][0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++;
            if (obs_stall !== exp_s[k]) begin
                n_bad++; $display("FAIL stall_pulse[%0d] got %b want %b", k, obs_stall, exp_s[k]);
            end
            n_cmp++;
            if (int'(rr_egr[0][0]) != exp_p[k]) begin
                n_bad++; $display("FAIL stall_ptr[%0d] got %0d want %0d", k, rr_egr[0][0], exp_p[k]);
            end
        end
        egr_req = '0;
    endtask

    task automatic test_hold_clear();
        quiet_reset();
        en = 1'b0;
        mid_req[0][0] = 1'b1; mid_gnt[0][0] = 1'b1; egr_req[1][1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (rr_mid[0][0] !== 2'd0 || rr_egr[1][1] !== 3'd5 || obs_stall !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d] got mid=%0d egr=%0d stall=%b want 0/5/0",
                         k, rr_mid[0][0], rr_egr[1][1], obs_stall);
            end
        end
        egr_req = '0; en = 1'b1;
        tick(); tick();
        n_cmp++;
        if (rr_mid[0][0] !== 2'd2) begin
            n_bad++; $display("FAIL clear_pre got %0d want 2", rr_mid[0][0]);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (rr_mid[0][0] !== 2'd0) begin
            n_bad++; $display("FAIL clear_seed got %0d want 0", rr_mid[0][0]);
        end
        mid_req = '0; mid_gnt = '0;
    endtask

    task automatic test_simultaneous();
        quiet_reset();
        en = 1'b1; egr_req[2][3] = 1'b1;
        tick(); tick();
        egr_gnt[2][3] = 1'b1;
        tick();
        n_cmp++;
        if (obs_stall !== 1'b0 || rr_egr[2][3] !== 3'd4) begin
            n_bad++;
            $display("FAIL simul_adv got stall=%b ptr=%0d want 0/4", obs_stall, rr_egr[2][3]);
        end
        egr_gnt[2][3] = 1'b0;
        tick(); tick();
        n_cmp++;
        if (obs_stall !== 1'b0 || rr_egr[2][3] !== 3'd4) begin
            n_bad++;
            $display("FAIL simul_restart got stall=%b ptr=%0d want 0/4", obs_stall, rr_egr[2][3]);
        end
        tick();
        n_cmp++;
        if (obs_stall !== 1'b1 || rr_egr[2][3] !== 3'd5) begin
            n_bad++;
            $display("FAIL simul_thresh got stall=%b ptr=%0d want 1/5", obs_stall, rr_egr[2][3]);
        end
        egr_req = '0;
    endtask

    task automatic test_reset_mid_stall();
        quiet_reset();
        en = 1'b1; egr_req[0][1] = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick();
        n_cmp++;
        if (obs_stall !== 1'b0 || rr_egr[0][1] !== 3'd1) begin
            n_bad++;
            $display("FAIL rst_stall_partial got stall=%b ptr=%0d want 0/1", obs_stall, rr_egr[0][1]);
        end
        tick();
        n_cmp++;
        if (obs_stall !== 1'b1 || rr_egr[0][1] !== 3'd2) begin
            n_bad++;
            $display("FAIL rst_stall_full got stall=%b ptr=%0d want 1/2", obs_stall, rr_egr[0][1]);
        end
        egr_req = '0;
    endtask

`ifdef CLOS_RR_SCHED_LFSR_EN
    task automatic test_lfsr();
        quiet_reset();
        en = 1'b1; mid_req[0][0] = 1'b1; mid_gnt[0][0] = 1'b1;
        tick();
        n_cmp++;
        if (rr_mid[0][0] !== 2'd2) begin
            n_bad++; $display("FAIL lfsr_first got %0d want 2", rr_mid[0][0]);
        end
        for (int k = 1; k < 100; k++) begin
            tick();
            n_cmp++;
            if (int'(rr_mid[0][0]) != mp[0][0]) begin
                n_bad++; $display("FAIL lfsr_seq[%0d] got %0d want %0d", k, rr_mid[0][0], mp[0][0]);
            end
        end
        mid_req = '0; mid_gnt = '0;
    endtask
`endif

    task automatic test_random();
        quiet_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int m = 0; m < M; m++)
                for (int r = 0; r < R; r++) begin
                    mid_req[m][r] = ($urandom_range(2, 0) != 0);
                    mid_gnt[m][r] = ($urandom_range(2, 0) == 0);
                end
            for (int r = 0; r < R; r++)
                for (int n = 0; n < N; n++) begin
                    egr_req[r][n] = ($urandom_range(2, 0) != 0);
                    egr_gnt[r][n] = ($urandom_range(2, 0) == 0);
                end
            en  = ($urandom_range(7, 0) != 0);
            clr = ($urandom_range(49, 0) == 0);
            rst = ($urandom_range(99, 0) == 0);
            tick();
            n_cmp++;
            if (obs_stall !== exp_stall) begin
                n_bad++; $display("FAIL rand_stall cyc %0d got %b want %b", cyc, obs_stall, exp_stall);
            end
            for (int m = 0; m < M; m++)
                for (int r = 0; r < R; r++) begin
                    n_cmp++;
                    if (int'(rr_mid[m][r]) != mp[m][r]) begin
                        n_bad++;
                        $display("FAIL rand_mid[%0d][%0d] cyc %0d got %0d want %0d",
                                 m, r, cyc, rr_mid[m][r], mp[m][r]);
                    end
                end
            for (int r = 0; r < R; r++)
                for (int n = 0; n < N; n++) begin
                    n_cmp++;
                    if (int'(rr_egr[r][n]) != ep[r][n]) begin
                        n_bad++;
                        $display("FAIL rand_egr[%0d][%0d] cyc %0d got %0d want %0d",
                                 r, n, cyc, rr_egr[r][n], ep[r][n]);
                    end
                end
        end
        rst = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        mid_req = '0; mid_gnt = '0; egr_req = '0; egr_gnt = '0;
        test_reset();
`ifdef CLOS_RR_SCHED_LFSR_EN
        test_lfsr();
`else
        test_handshake();
        test_stall();
        test_hold_clear();
        test_simultaneous();
        test_reset_mid_stall();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clos_rr_sched.md
CLOS_RR_SCHED -- requirements
Module: clos_rr_sched

Interface
REQ-001 The block SHALL have parameter ClosN, default 4, meaning banks per egress node.
REQ-002 The block SHALL have parameter ClosM, default 8, meaning number of middle nodes.
REQ-003 The block SHALL have parameter ClosR, default 4, meaning number of ingress/egress nodes.
REQ-004 The block SHALL have parameter StallThresh, default 15, meaning consecutive blocked cycles before a forced pointer advance.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk_i  input  1  clock.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 en_i  input  1  pointer update enable.
REQ-008 clr_i  input  1  synchronous reload of pointers to seed values.
REQ-009 mid_req_i  input  [ClosM][ClosR]  middle node output request per arbiter.
REQ-010 mid_gnt_i  input  [ClosM][ClosR]  grant returned to that middle output.
REQ-011 egr_req_i  input  [ClosR][ClosN]  egress node bank request per arbiter.
REQ-012 egr_gnt_i  input  [ClosR][ClosN]  bank grant.
REQ-013 rr_mid_o  output  [ClosM][ClosR][$clog2(ClosR)]  priority pointer per middle arbiter.
REQ-014 rr_egr_o  output  [ClosR][ClosN][$clog2(ClosM)]  priority pointer per egress arbiter.
REQ-015 stall_o  output  1  pulse: at least one arbiter hit StallThresh this cycle.

Function
REQ-016 Each arbiter SHALL own one pointer register and one stall counter of width $clog2(StallThresh+1).
REQ-017 Seed values SHALL be: mid[m][r] = (m+r) mod ClosR; egr[r][n] = (r*ClosN+n) mod ClosM.
REQ-018 Handshake event per arbiter SHALL be req & gnt in the same cycle.
REQ-019 On a handshake with en_i=1, the pointer SHALL advance by one modulo its arbiter size, visible the next cycle.
REQ-020 Stall counter SHALL increment on req & !gnt with en_i=1, and SHALL clear on a handshake or when req=0.
REQ-021 When a stall counter would reach StallThresh, the pointer SHALL advance by one, the counter SHALL clear, and stall_o SHALL be 1 that cycle.
REQ-022 Handshake and stall advance in the same cycle SHALL produce a single advance.
REQ-023 Pointer wrap SHALL be natural modulo 2^width (size-1 -> 0).
REQ-024 With en_i=0, pointers and counters SHALL hold, and stall_o SHALL be 0.
REQ-025 clr_i=1 SHALL reload seeds and clear counters next cycle, overriding en_i and any events.
REQ-026 Outputs SHALL be registered only, with no combinational path from inputs to rr_*_o.
REQ-027 stall_o SHALL be combinational from counter state and current req/gnt (zero latency).

Reset
REQ-028 rst_i SHALL load all pointers with their seeds and clear all counters.
REQ-029 rst_i SHALL take priority over clr_i and en_i.
REQ-030 After reset, stall_o SHALL be 0 while no req is asserted.
REQ-031 Reset asserted mid-stall SHALL discard the partial count.

Configuration
REQ-032 Macro CLOS_RR_SCHED_LFSR_EN SHALL select the pointer advance step.
REQ-033 Without CLOS_RR_SCHED_LFSR_EN, each advance SHALL be +1 (REQ-019, REQ-021).
REQ-034 With CLOS_RR_SCHED_LFSR_EN, one 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, reset/clr value 16'hACE1) SHALL step each cycle en_i=1.
REQ-035 With CLOS_RR_SCHED_LFSR_EN, each advance SHALL be ptr + 1 + lfsr[w-1:0] mod 2^w, where w is the pointer width.
REQ-036 Elaboration SHALL fail if ClosN, ClosM or ClosR is not a power of two >= 2, or if StallThresh < 1.

Verification (ClosN=4, ClosM=8, ClosR=4, StallThresh=3, macro off unless stated)
REQ-037 Reset scenario: after reset -> rr_mid_o[2][3]=1, rr_egr_o[1][2]=6, stall_o=0.
REQ-038 Handshake scenario: mid_req/gnt[0][0]=1 for 5 cycles with en_i=1 -> rr_mid_o[0][0] sequence 0,1,2,3,0,1 (wrap checked).
REQ-039 Stall scenario: egr_req[0][0]=1, gnt=0 for 3 cycles -> stall_o=1 on 3rd cycle, rr_egr_o[0][0] goes 0->1, counter restarts.
REQ-040 Hold and clear scenario: en_i=0 with handshakes -> pointers frozen; clr_i pulse after 2 advances -> seeds restored next cycle.
REQ-041 Simultaneous-events scenario: handshake on the cycle the counter reaches threshold -> single +1 advance, no double step.
REQ-042 LFSR scenario (macro on): first advance of rr_mid_o[0][0] = (0+1+(lfsr value & 3)) mod 4 per the golden LFSR model; sequence matches model for 100 events.
